write_ports_cam: RTL and testbench
==================================

# write_ports_cam

Write-side companion of the 8-entry x 4-bit CAM lookup port. It owns the CAM storage and per-entry valid bits, and accepts three commands: direct write by address, allocate into the lowest free slot, and delete by value. It presents the stored words and valid bits to the lookup path combinationally from registers. It also reports occupancy and per-command completion pulses to the controlling logic.

## Interface
Parameters:
- DEPTH, 8, number of entries; fixed at 8, so addresses are 3 bits.
- WIDTH, 4, bits per stored word.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wr_en  input  1  direct-write command.
- wr_addr  input  3  target entry for wr_en.
- wr_data  input  4  word for wr_en.
- alloc_en  input  1  allocate command.
- alloc_data  input  4  word for alloc_en.
- del_en  input  1  delete-by-value command.
- del_data  input  4  value to invalidate.
- q  output  4 x [7:0]  stored words, unpacked array indexed by entry.
- entry_valid  output  8  per-entry valid bits.
- alloc_ok  output  1  one-cycle pulse: allocation succeeded.
- alloc_fail  output  1  one-cycle pulse: allocation rejected because the CAM is full.
- alloc_addr  output  3  slot used by the last successful allocation; holds its value until the next success.
- del_hit  output  1  one-cycle pulse: delete invalidated at least one entry.
- count  output  4  number of valid entries, 0 to 8.
- full  output  1  count == 8.
- empty  output  1  count == 0.

## Operation
- At most one command executes per cycle. Priority is wr_en > alloc_en > del_en. Lower-priority commands asserted in the same cycle are dropped silently and produce no pulses.
- **Direct write:** q[wr_addr] <= wr_data and entry_valid[wr_addr] <= 1. Overwriting an already-valid entry is legal and leaves count unchanged.
- **Allocate:** the target is the lowest-indexed entry with entry_valid == 0.
  - If such an entry exists: write alloc_data there, set its valid bit, set alloc_addr to that index, pulse alloc_ok.
  - If full: no state change, pulse alloc_fail; alloc_addr keeps its previous value.
- **Delete:** every entry whose valid bit is 1 and whose q equals del_data gets valid <= 0 and q <= 0.
  - Multiple matches are all cleared in the same cycle.
  - del_hit pulses if any entry was cleared. No match means no state change and no pulse.
- count, full and empty are registered and updated in the same edge as the entry they describe, so they always match entry_valid.
- Invalid entries hold q = 0. The lookup path must AND its match vector with entry_valid.

## Timing
- The command is sampled at rising edge N. q, entry_valid, count, full, empty, alloc_addr and all pulses reflect it from edge N onward, i.e. with 1-cycle latency.
- Pulses (alloc_ok, alloc_fail, del_hit) are high for exactly one cycle. They fall at the next edge unless a new qualifying command arrives.
- Back-to-back commands are legal every cycle with no stall. An allocate in cycle N+1 sees the valid bits updated by the command in cycle N.
- Reset values: q all 0, entry_valid 8'h00, count 0, empty 1, full 0, alloc_addr 0, all pulses 0.
- Reset asserted mid-stream aborts the current command. The first command after reset deasserts is executed normally on the next rising edge.

## Structure
- Shared package cam_pkg holds:
  - localparams CAM_DEPTH = 8 and CAM_WIDTH = 4;
  - typedefs cam_addr_t (logic [2:0]) and cam_data_t (logic [3:0]).
  - The lookup port is expected to adopt this package as well.
- One sub-module, free_slot_finder: a combinational lowest-zero encoder. Input is the 8-bit valid vector; outputs are a 3-bit index and a found flag.
- Storage, valid bits, count and pulse registers live in write_ports_cam.

## Test plan
- Reset, then 8 allocates of 4'h1..4'h8 -> alloc_addr steps 0..7 with alloc_ok each cycle; afterwards count = 8 and full = 1. A 9th allocate -> alloc_fail = 1, no state change, alloc_addr stays 7.
- Direct write entry 5 = 4'hA into an empty CAM -> entry_valid = 8'h20, count = 1. Rewrite entry 5 = 4'hB -> count stays 1, q[5] = 4'hB.
- Fill entries 2, 4, 6 with 4'h3, then delete 4'h3 -> del_hit = 1, all three valid bits clear, count drops by 3. Repeat the delete -> del_hit = 0.
- Full CAM, delete the value stored in entry 3, then allocate 4'hC -> alloc_addr = 3, full = 1 again.
- Same cycle: wr_en (addr 0, 4'h9) with alloc_en and del_en -> only the write occurs; no alloc_ok or del_hit pulses.
- Assert reset asynchronously between edges during an allocate stream -> all outputs take reset values immediately; the next allocate after release lands in slot 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared CAM definitions for the write and lookup ports.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cam_pkg;

  localparam int CAM_DEPTH = 8;
  localparam int CAM_WIDTH = 4;

  typedef logic [2:0] cam_addr_t;
  typedef logic [3:0] cam_data_t;

  // Number of set bits in a valid vector, 0..8.
  function automatic logic [3:0] cam_popcount(input logic [CAM_DEPTH-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-zero encoder over the CAM valid vector.
// Latency: purely combinational.
// Backpressure: none; found=0 tells the caller the CAM is full.
module free_slot_finder
  import cam_pkg::*;
(
  input  logic [CAM_DEPTH-1:0] valid,
  output cam_addr_t            idx,
  output logic                 found
);

  // Scan from the top down so the last hit written is the lowest free index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_ports_cam.sv
// CAM storage with direct-write, allocate-lowest-free and delete-by-value commands.
// Latency: one cycle; every output reflects the command sampled at the previous edge.
// Backpressure: none; one command per cycle, priority wr > alloc > del, losers dropped.
module write_ports_cam
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  parameter int WIDTH = CAM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  cam_addr_t        wr_addr,
  input  cam_data_t        wr_data,
  input  logic             alloc_en,
  input  cam_data_t        alloc_data,
  input  logic             del_en,
  input  cam_data_t        del_data,
  output logic [WIDTH-1:0] q [DEPTH],
  output logic [DEPTH-1:0] entry_valid,
  output logic             alloc_ok,
  output logic             alloc_fail,
  output cam_addr_t        alloc_addr,
  output logic             del_hit,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  cam_addr_t        alloc_addr_q, alloc_addr_d;
  logic             alloc_ok_q, alloc_ok_d;
  logic             alloc_fail_q, alloc_fail_d;
  logic             del_hit_q, del_hit_d;
  logic [3:0]       count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  cam_addr_t free_idx;
  logic      free_found;

  free_slot_finder u_free_slot_finder (
    .valid (valid_q),
    .idx   (free_idx),
    .found (free_found)
  );

  // Next-state for storage, valid bits, pulses and occupancy from the winning command.
  always_comb begin
    mem_d        = mem_q;
    valid_d      = valid_q;
    alloc_addr_d = alloc_addr_q;
    alloc_ok_d   = 1'b0;
    alloc_fail_d = 1'b0;
    del_hit_d    = 1'b0;

    if (wr_en) begin
      mem_d[wr_addr]   = wr_data;
      valid_d[wr_addr] = 1'b1;
    end else if (alloc_en) begin
      if (free_found) begin
        mem_d[free_idx]   = alloc_data;
        valid_d[free_idx] = 1'b1;
        alloc_addr_d      = free_idx;
        alloc_ok_d        = 1'b1;
      end else begin
        alloc_fail_d = 1'b1;
      end
    end else if (del_en) begin
      // Invalid entries already hold zero, so only valid matches need clearing.
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (mem_q[i] == del_data)) begin
          mem_d[i]   = '0;
          valid_d[i] = 1'b0;
          del_hit_d  = 1'b1;
        end
      end
    end

    // Occupancy derived from the same next-state valid vector keeps it in lockstep.
    count_d = cam_popcount(valid_d);
    full_d  = (count_d == 4'd8);
    empty_d = (count_d == 4'd0);
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q      <= '0;
      alloc_addr_q <= '0;
      alloc_ok_q   <= 1'b0;
      alloc_fail_q <= 1'b0;
      del_hit_q    <= 1'b0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      mem_q        <= mem_d;
      valid_q      <= valid_d;
      alloc_addr_q <= alloc_addr_d;
      alloc_ok_q   <= alloc_ok_d;
      alloc_fail_q <= alloc_fail_d;
      del_hit_q    <= del_hit_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  assign q           = mem_q;
  assign entry_valid = valid_q;
  assign alloc_addr  = alloc_addr_q;
  assign alloc_ok    = alloc_ok_q;
  assign alloc_fail  = alloc_fail_q;
  assign del_hit     = del_hit_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;

endmodule

// File: tb/tb_write_ports_cam.sv
// Scoreboard bench for write_ports_cam: directed scenarios plus random commands.
// Latency: expected state pushed at the driving negedge, checked after the next posedge.
// Backpressure: n/a.
module tb_write_ports_cam;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, alloc_en, del_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data, alloc_data, del_data;
  logic [3:0] q [8];
  logic [7:0] entry_valid;
  logic       alloc_ok, alloc_fail, del_hit, full, empty;
  logic [2:0] alloc_addr;
  logic [3:0] count;

  write_ports_cam dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_data (alloc_data),
    .del_en     (del_en),
    .del_data   (del_data),
    .q          (q),
    .entry_valid(entry_valid),
    .alloc_ok   (alloc_ok),
    .alloc_fail (alloc_fail),
    .alloc_addr (alloc_addr),
    .del_hit    (del_hit),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][3:0] mem;
    logic [7:0]      valid;
    logic [3:0]      count;
    logic            full;
    logic            empty;
    logic [2:0]      addr;
    logic            ok;
    logic            fail;
    logic            hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain arrays of words and valid flags.
  logic [3:0] m_mem [8];
  bit         m_val [8];
  logic [2:0] m_addr;

  function automatic exp_t model_snapshot(bit ok, bit fail, bit hit);
    exp_t e;
    int   n = 0;
    for (int i = 0; i < 8; i++) begin
      e.mem[i]   = m_mem[i];
      e.valid[i] = m_val[i];
      n += m_val[i] ? 1 : 0;
    end
    e.count = 4'(n);
    e.full  = (n == 8);
    e.empty = (n == 0);
    e.addr  = m_addr;
    e.ok    = ok;
    e.fail  = fail;
    e.hit   = hit;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 4'h0;
      m_val[i] = 1'b0;
    end
    m_addr = 3'd0;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_dut(exp_t e);
    logic [7:0][3:0] act_mem;
    for (int i = 0; i < 8; i++) act_mem[i] = q[i];
    cmp("q", act_mem, e.mem);
    cmp("entry_valid", {24'd0, entry_valid}, {24'd0, e.valid});
    cmp("count", {28'd0, count}, {28'd0, e.count});
    cmp("full", {31'd0, full}, {31'd0, e.full});
    cmp("empty", {31'd0, empty}, {31'd0, e.empty});
    cmp("alloc_addr", {29'd0, alloc_addr}, {29'd0, e.addr});
    cmp("alloc_ok", {31'd0, alloc_ok}, {31'd0, e.ok});
    cmp("alloc_fail", {31'd0, alloc_fail}, {31'd0, e.fail});
    cmp("del_hit", {31'd0, del_hit}, {31'd0, e.hit});
  endtask

  // Drive one command at the falling edge and push what the next rising edge must produce.
  task automatic cmd(bit w, logic [2:0] wa, logic [3:0] wd,
                     bit a, logic [3:0] ad, bit d, logic [3:0] dd);
    bit ok = 0, fail = 0, hit = 0, found = 0;
    @(negedge clk);
    wr_en = w; wr_addr = wa; wr_data = wd;
    alloc_en = a; alloc_data = ad;
    del_en = d; del_data = dd;
    if (w) begin
      m_mem[wa] = wd;
      m_val[wa] = 1'b1;
    end else if (a) begin
      for (int i = 0; i < 8 && !found; i++) begin
        if (!m_val[i]) begin
          found = 1; m_mem[i] = ad; m_val[i] = 1'b1; m_addr = 3'(i); ok = 1;
        end
      end
      if (!found) fail = 1;
    end else if (d) begin
      for (int i = 0; i < 8; i++) begin
        if (m_val[i] && m_mem[i] == dd) begin
          m_val[i] = 1'b0; m_mem[i] = 4'h0; hit = 1;
        end
      end
    end
    exp_q.push_back(model_snapshot(ok, fail, hit));
  endtask

  task automatic idle();
    cmd(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(logic [3:0] v);
    cmd(0, 0, 0, 1, v, 0, 0);
  endtask

  task automatic wr(logic [2:0] a, logic [3:0] v);
    cmd(1, a, v, 0, 0, 0, 0);
  endtask

  task automatic del(logic [3:0] v);
    cmd(0, 0, 0, 0, 0, 1, v);
  endtask

  task automatic clear_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    alloc_en = 0; alloc_data = 0; del_en = 0; del_data = 0;
  endtask

  // Synchronous-looking reset applied at a falling edge, checked immediately.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    #1 check_dut(model_snapshot(0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check_dut(exp_q.pop_front());
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #1 check_dut(model_snapshot(0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // Fill via allocation, then one allocation too many.
    for (int i = 1; i <= 8; i++) alloc(4'(i));
    alloc(4'hF);
    idle();

    // Direct write into an empty CAM, then overwrite the same entry.
    do_reset();
    wr(3'd5, 4'hA);
    wr(3'd5, 4'hB);
    idle();

    // Multi-match delete, then a repeat that must miss.
    wr(3'd2, 4'h3);
    wr(3'd4, 4'h3);
    wr(3'd6, 4'h3);
    del(4'h3);
    del(4'h3);
    idle();

    // Free a hole in a full CAM and reallocate into it.
    do_reset();
    for (int i = 1; i <= 8; i++) alloc(4'(i));
    del(4'h4);
    alloc(4'hC);
    idle();

    // Simultaneous commands: only the write may take effect.
    do_reset();
    alloc(4'h1);
    cmd(1, 3'd0, 4'h9, 1, 4'h7, 1, 4'h1);
    idle();

    // Asynchronous reset in the middle of an allocate stream.
    alloc(4'h2);
    alloc(4'h3);
    alloc(4'h4);
    @(negedge clk);
    alloc_en = 1'b1; alloc_data = 4'h5;
    #2 reset = 1'b1;
    exp_q.delete();
    model_reset();
    #1 check_dut(model_snapshot(0, 0, 0));
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    alloc(4'h6);
    idle();

    // Random commands with a narrow data range so deletes hit often.
    for (int n = 0; n < 300; n++) begin
      cmd(bit'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
          bit'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)));
    end
    idle();

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
